// File: rtl/ll_pkg.sv
// Shared types and constants for the runtime-exponent Lucas-Lehmer engine.
package ll_pkg;

  localparam int PMAX_DEF = 31;
  localparam int SQW      = 2 * PMAX_DEF + 1;
  localparam int P_MIN    = 2;
  localparam int INIT_S   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SQUARE = 3'd2,
    ST_REDUCE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RESULT = 3'd5
  } state_e;

  // All-ones mask of the low p bits, i.e. the Mersenne number 2^p - 1.
  function automatic logic [SQW-1:0] mask_m(input logic [7:0] p);
    return (SQW'(1'b1) << p) - SQW'(1'b1);
  endfunction

endpackage

// File: rtl/mersenne_fold_rt.sv
// Combinational reduction of a square-path value modulo 2^p - 1 for a runtime p.
module mersenne_fold_rt
  import ll_pkg::*;
#(
  parameter int PMAX = PMAX_DEF
) (
  input  logic [2*PMAX:0] sq_i,
  input  logic [7:0]      p_i,
  output logic [PMAX-1:0] s_o
);

  localparam int SQ_W = 2 * PMAX + 1;

  logic [SQ_W-1:0] m_s;
  logic [SQ_W-1:0] x_s;

  // Inputs are bounded by M^2 + M, so three end-around folds always land below 2M.
  always_comb begin
    m_s = SQ_W'(mask_m(p_i));
    x_s = sq_i;
    for (int i = 0; i < 3; i++) begin
      x_s = (x_s & m_s) + (x_s >> p_i);
    end
    if (x_s >= m_s) begin
      x_s = x_s - m_s;
    end else begin
      x_s = x_s;
    end
    s_o = x_s[PMAX-1:0];
  end

endmodule

// File: rtl/ll_mersenne_engine.sv
// Lucas-Lehmer engine testing M_p = 2^p - 1 for a per-request exponent p.
module ll_mersenne_engine
  import ll_pkg::*;
#(
  parameter int PMAX = PMAX_DEF,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_p,
  input  logic          abort,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_prime,
  output logic          res_err,
  output logic [7:0]    res_p,
  output logic [CW-1:0] res_cycles
);

  localparam int SQ_W = 2 * PMAX + 1;

  state_e          state_q, state_d;
  logic [PMAX-1:0] s_q, s_d;
  logic [PMAX-1:0] m_q, m_d;
  logic [SQ_W-1:0] sq_q, sq_d;
  logic [7:0]      iter_q, iter_d;
  logic [7:0]      p_q, p_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            res_valid_q, res_valid_d;
  logic            res_prime_q, res_prime_d;
  logic            res_err_q, res_err_d;
  logic [PMAX-1:0] fold_s;
  logic [SQ_W-1:0] s_ext_s;

  mersenne_fold_rt #(.PMAX(PMAX)) u_fold (
    .sq_i (sq_q),
    .p_i  (p_q),
    .s_o  (fold_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      m_q         <= '0;
      sq_q        <= '0;
      iter_q      <= 8'd0;
      p_q         <= 8'd0;
      cyc_q       <= '0;
      res_valid_q <= 1'b0;
      res_prime_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      m_q         <= m_d;
      sq_q        <= sq_d;
      iter_q      <= iter_d;
      p_q         <= p_d;
      cyc_q       <= cyc_d;
      res_valid_q <= res_valid_d;
      res_prime_q <= res_prime_d;
      res_err_q   <= res_err_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    m_d         = m_q;
    sq_d        = sq_q;
    iter_d      = iter_q;
    p_d         = p_q;
    cyc_d       = cyc_q;
    res_valid_d = res_valid_q;
    res_prime_d = res_prime_q;
    res_err_d   = res_err_q;
    s_ext_s     = SQ_W'(s_q);

    // The counter runs through the edge that enters RESULT, then freezes.
    if (state_q != ST_IDLE && state_q != ST_RESULT) begin
      cyc_d = (cyc_q == {CW{1'b1}}) ? cyc_q : cyc_q + CW'(1'b1);
    end else begin
      cyc_d = cyc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          p_d         = req_p;
          cyc_d       = CW'(1'b1);
          res_prime_d = 1'b0;
          res_err_d   = 1'b0;
          if (req_p < 8'(P_MIN) || req_p > 8'(PMAX)) begin
            state_d     = ST_RESULT;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
          end else if (req_p == 8'(P_MIN)) begin
            state_d     = ST_RESULT;
            res_prime_d = 1'b1;
            res_valid_d = 1'b1;
          end else begin
            state_d = ST_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        s_d     = PMAX'(INIT_S);
        iter_d  = 8'd0;
        m_d     = PMAX'(mask_m(p_q));
        state_d = ST_SQUARE;
      end
      ST_SQUARE: begin
        // Adding M keeps the subtraction non-negative when s is 0 or 1.
        sq_d    = s_ext_s * s_ext_s + SQ_W'(m_q) - SQ_W'(2'd2);
        state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        s_d     = fold_s;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        iter_d = iter_q + 8'd1;
        if (iter_q == p_q - 8'd3) begin
          state_d     = ST_RESULT;
          res_prime_d = (s_q == '0);
          res_valid_d = 1'b1;
        end else begin
          state_d = ST_SQUARE;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign res_valid  = res_valid_q;
  assign res_prime  = res_prime_q;
  assign res_err    = res_err_q;
  assign res_p      = p_q;
  assign res_cycles = cyc_q;

endmodule

// File: tb/tb_ll_mersenne_engine.sv
// Scoreboard bench for ll_mersenne_engine: expectations come from a modulo-arithmetic LL model.
module tb_ll_mersenne_engine;
  import ll_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_p = 8'd0;
  logic          abort = 1'b0;
  logic          busy;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          res_prime;
  logic          res_err;
  logic [7:0]    res_p;
  logic [CW-1:0] res_cycles;

  typedef struct {
    logic [7:0]    p;
    logic          prime;
    logic          err;
    logic [CW-1:0] cycles;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  ll_mersenne_engine #(.PMAX(31), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .abort(abort), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_prime(res_prime), .res_err(res_err),
    .res_p(res_p), .res_cycles(res_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit ll_prime(input int p);
    longint unsigned m, s;
    if (p == 2) return 1'b1;
    m = (64'd1 << p) - 64'd1;
    s = 64'd4;
    for (int i = 0; i < p - 2; i++) s = (s * s + m - 64'd2) % m;
    return s == 64'd0;
  endfunction

  task automatic send(input logic [7:0] p);
    exp_t e;
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    e.p      = p;
    e.err    = (p < 8'd2) || (p > 8'd31);
    e.prime  = !e.err && ll_prime(int'(p));
    e.cycles = (e.err || p == 8'd2) ? CW'(1) : CW'(3 * int'(p) - 4);
    q.push_back(e);
    req_valid = 1'b1;
    req_p = p;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      $display("FAIL accept p=%0d: busy=%b req_ready=%b, required busy=1 req_ready=0", p, busy, req_ready);
      fails++;
    end
  endtask

  task automatic wait_result(input int hold);
    exp_t e;
    int n = 0;
    while (res_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (res_valid !== 1'b1 || q.size() == 0) begin
      $display("FAIL result_wait: res_valid=%b queued=%0d, required res_valid=1 with a queued entry", res_valid, q.size());
      fails++;
      return;
    end
    e = q.pop_front();
    checks++;
    if (res_prime !== e.prime) begin
      $display("FAIL prime p=%0d: got %b, required %b", e.p, res_prime, e.prime); fails++;
    end
    checks++;
    if (res_err !== e.err) begin
      $display("FAIL err p=%0d: got %b, required %b", e.p, res_err, e.err); fails++;
    end
    checks++;
    if (res_p !== e.p) begin
      $display("FAIL res_p: got %0d, required %0d", res_p, e.p); fails++;
    end
    checks++;
    if (res_cycles !== e.cycles) begin
      $display("FAIL cycles p=%0d: got %0d, required %0d", e.p, res_cycles, e.cycles); fails++;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_prime !== e.prime || res_err !== e.err || res_p !== e.p ||
          res_cycles !== e.cycles || req_ready !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL hold%0d: valid=%b prime=%b err=%b p=%0d cyc=%0d rdy=%b busy=%b, required 1 %b %b %0d %0d 0 1",
                 i, res_valid, res_prime, res_err, res_p, res_cycles, req_ready, busy,
                 e.prime, e.err, e.p, e.cycles);
        fails++;
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL retire: res_valid=%b req_ready=%b, required 0 and 1", res_valid, req_ready);
      fails++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (res_valid !== 1'b0 || res_prime !== 1'b0 || res_err !== 1'b0 || res_p !== 8'd0 ||
        res_cycles !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL reset: valid=%b prime=%b err=%b p=%0d cyc=%0d busy=%b rdy=%b, required 0 0 0 0 0 0 1",
               res_valid, res_prime, res_err, res_p, res_cycles, busy, req_ready);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_p7_sequence();
    logic [31:0] exp_s [5];
    int k = 0;
    int n = 0;
    exp_s[0] = 32'd14; exp_s[1] = 32'd67; exp_s[2] = 32'd42; exp_s[3] = 32'd111; exp_s[4] = 32'd0;
    send(8'd7);
    while (k < 5 && n < 200) begin
      @(negedge clk); n++;
      if (dut.state_q == ST_CHECK) begin
        checks++;
        if (32'(dut.s_q) !== exp_s[k]) begin
          $display("FAIL s_seq[%0d]: got %0d, required %0d", k, dut.s_q, exp_s[k]); fails++;
        end
        k++;
      end
    end
    checks++;
    if (k != 5) begin
      $display("FAIL s_seq_count: got %0d, required 5", k); fails++;
    end
    wait_result(0);
  endtask

  task automatic test_primes();
    send(8'd13); wait_result(0);
    send(8'd11); wait_result(0);
    send(8'd31); wait_result(0);
  endtask

  task automatic test_range();
    send(8'd2);  wait_result(0);
    send(8'd1);  wait_result(0);
    send(8'd40); wait_result(0);
    send(8'd0);  wait_result(0);
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    send(8'd13);
    wait_result(10);
  endtask

  task automatic test_abort();
    int n = 0;
    send(8'd17);
    while (!(dut.state_q == ST_CHECK && dut.iter_q == 8'd5) && n < 200) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    void'(q.pop_back());
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL abort_check: busy=%b valid=%b rdy=%b, required 0 0 1", busy, res_valid, req_ready);
      fails++;
    end
    n = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (res_valid === 1'b1) n++; end
    checks++;
    if (n != 0) begin
      $display("FAIL abort_silent: res_valid high %0d cycles, required 0", n); fails++;
    end
    send(8'd17); wait_result(0);
    // Abort while a result is pending discards it.
    res_ready = 1'b0;
    send(8'd2);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    res_ready = 1'b1;
    void'(q.pop_back());
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort_result: valid=%b busy=%b, required 0 0", res_valid, busy); fails++;
    end
    // Abort in IDLE is ignored, and the simultaneous request is accepted.
    abort = 1'b1;
    send(8'd5);
    abort = 1'b0;
    wait_result(0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send(8'd13);
    while (dut.state_q != ST_SQUARE && n < 50) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    checks++;
    if (res_valid !== 1'b0 || res_prime !== 1'b0 || res_err !== 1'b0 || res_p !== 8'd0 ||
        res_cycles !== '0 || busy !== 1'b0) begin
      $display("FAIL reset_mid: valid=%b prime=%b err=%b p=%0d cyc=%0d busy=%b, required all 0",
               res_valid, res_prime, res_err, res_p, res_cycles, busy);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ready_after_reset: got %b, required 1", req_ready); fails++;
    end
    send(8'd5); wait_result(0);
  endtask

  initial begin
    test_reset();
    test_p7_sequence();
    test_primes();
    test_range();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ll_mersenne_engine.md
Name: ll_mersenne_engine

Overview:
- Runtime-exponent Lucas-Lehmer primality engine: tests M_p = 2^p - 1 for any p up to parameter PMAX, with p supplied per request.
- Replaces the per-exponent fixed testers with one shared datapath.
- Request uses a valid/ready handshake; the result is held until the consumer accepts it. Supports abort and reports cycle count and error status.
- Sits behind the Mersenne test controller; one request in flight at a time.

Parameters:
- PMAX, 31, largest supported exponent; the s register is PMAX bits, the square path is 2*PMAX+1 bits.
- CW, 16, width of the cycle counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept; high only in IDLE
- req_p  in  8  exponent p, sampled on handshake
- abort  in  1  cancel current test
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_prime  out  1  1 when M_p is prime
- res_err  out  1  p was out of range
- res_p  out  8  echo of the tested p
- res_cycles  out  CW  clock edges from acceptance to res_valid rising

Behaviour:
- Reset values: all outputs 0 (req_ready is 1 after reset because the state is IDLE); state IDLE; s, iter and cycle count 0.
- States: IDLE, INIT, SQUARE, REDUCE, CHECK, RESULT.
- Handshake: a request is accepted on the edge where req_valid && req_ready; req_p is latched on that edge.
- Acceptance routing:
  - p < 2 or p > PMAX: go to RESULT with res_err=1, res_prime=0, cycles=1.
  - p == 2: go to RESULT with res_prime=1, cycles=1.
  - otherwise: go to INIT.
- INIT: s <= 4, iter <= 0, M = (1<<p)-1.
- SQUARE: sq <= s*s + M - 2. Adding M avoids underflow when s < 2; sq is 2*PMAX+1 bits.
- REDUCE: s <= mersenne_fold_rt(sq, p).
- CHECK: iter <= iter+1. If iter == p-3, go to RESULT with res_prime = (s==0); else go to SQUARE.
- Iteration count is p-2, at 3 cycles per iteration.
- Latency: res_cycles = 3p-4 (p=7 gives 17, p=13 gives 35, p=31 gives 89).
- Cycle counter: starts at 1 on the acceptance edge, increments on every non-IDLE edge before RESULT, and saturates at 2^CW-1.
- RESULT: res_valid=1, and res_* stay stable until res_valid && res_ready. On that edge, go to IDLE with res_valid=0.
- req_ready stays 0 from acceptance until IDLE is re-entered, so no back-to-back acceptance on the same edge as result retirement.
- Abort:
  - abort high in any state other than IDLE: go to IDLE on the next edge, res_valid=0, and no result is produced. This includes RESULT, where the pending result is discarded.
  - abort in IDLE is ignored. With abort and req_valid both high in IDLE, the request is accepted.
- Reset mid-test: immediate return to IDLE; all outputs 0.
- Arithmetic invariants: s < M always after REDUCE; the reduction is exact modulo M, with the representation M mapped to 0.

Decomposition:
- Shared package ll_pkg holds:
  - the state enum;
  - localparams SQW = 2*PMAX+1, P_MIN = 2, INIT_S = 4;
  - a function mask_m(p) returning (1<<p)-1.
- Sub-module mersenne_fold_rt (combinational, runtime p):
  - fold 3 times: x = (x & M) + (x >> p);
  - then if x >= M, subtract M;
  - output PMAX bits.

Test Plan:
- p=7 with res_ready held high: after REDUCE stages, s sequence is 14, 67, 42, 111, 0. Then res_prime=1, res_cycles=17, res_p=7.
- p=13 gives res_prime=1, res_cycles=35. Then p=11 gives res_prime=0 (2047 = 23*89), res_cycles=29. p=31 gives res_prime=1, res_cycles=89.
- p=2 gives res_prime=1, res_err=0, res_cycles=1. p=1 and p=40 (PMAX=31) give res_err=1, res_prime=0, res_cycles=1.
- Backpressure: p=13 with res_ready low for 10 cycles after res_valid. Required: res_* stable, req_ready=0, busy=1. On res_ready=1, retire on that edge and req_ready=1 on the next cycle.
- Abort during p=17 at CHECK of iter 5: IDLE on the next edge, and res_valid never rises. A new p=17 request then completes with res_prime=1, res_cycles=47.
- rst_n asserted mid-SQUARE: all outputs 0 immediately. After release, req_ready=1 and a p=5 request gives res_prime=1, res_cycles=11.
